// File: rtl/nonogram_pkg.sv
// Shared types and sizing for the nonogram solver: board dimension, line indexing
// and the feeder state encoding.
package nonogram_pkg;

    localparam int SIZE   = 3;
    localparam int LINES  = 2 * SIZE;
    localparam int LIDX_W = $clog2(LINES);
    localparam int QCNT_W = $clog2(LINES + 1);
    localparam int CNT_W  = 7;

    typedef logic [SIZE-1:0]   opt_t;
    typedef logic [LIDX_W-1:0] lidx_t;

    typedef enum logic [2:0] {
        LOAD,
        HDR,
        OPTS,
        WAIT,
        DONE
    } feeder_state_t;

    // LINES need not be a power of two, so pointers wrap explicitly.
    function automatic lidx_t lidx_inc(input lidx_t i);
        return (i == lidx_t'(LINES - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/line_queue.sv
// Circular work-queue of line indices, depth LINES. A bulk init loads every line
// whose mask bit is set, in ascending index order.
module line_queue
    import nonogram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic [LINES-1:0]  init_mask_i,
    input  logic              push_i,
    input  lidx_t             push_idx_i,
    input  logic              pop_i,
    output lidx_t             head_o,
    output logic              empty_o,
    output logic [QCNT_W-1:0] count_o
);

    lidx_t             mem_q [LINES];
    lidx_t             head_q;
    lidx_t             tail_q;
    logic [QCNT_W-1:0] count_q;

    lidx_t             init_mem [LINES];
    logic [QCNT_W-1:0] init_n;

    always_comb begin
        init_n = '0;
        for (int i = 0; i < LINES; i++) init_mem[i] = '0;
        for (int i = 0; i < LINES; i++) begin
            if (init_mask_i[i]) begin
                init_mem[init_n] = lidx_t'(i);
                init_n           = init_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init_i) begin
            for (int i = 0; i < LINES; i++) mem_q[i] <= init_mem[i];
        end else if (push_i) begin
            mem_q[tail_q] <= push_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (init_i) begin
            head_q  <= '0;
            tail_q  <= (init_n == QCNT_W'(LINES)) ? '0 : lidx_t'(init_n);
            count_q <= init_n;
        end else begin
            if (push_i) tail_q <= lidx_inc(tail_q);
            if (pop_i)  head_q <= lidx_inc(head_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[head_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/line_option_feeder.sv
// Upstream stage of the nonogram solver: stores candidate options per line and streams
// queued lines (header word, then options) to the solver, re-queueing on put-back.
module line_option_feeder
    import nonogram_pkg::*;
#(
    parameter int MAX_OPTS = 8,
    parameter int FB_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    input  lidx_t                       load_line,
    input  opt_t                        load_opt,
    input  logic                        load_done,
    output logic                        started,
    output opt_t                        option,
    output logic                        valid_op,
    output logic [LINES-1:0][CNT_W-1:0] old_options_amnt,
    input  logic                        put_back_to_FIFO,
    input  logic                        solved,
    output logic                        done,
    output logic                        stuck,
    output logic                        load_err,
    output feeder_state_t               state_dbg
);

    localparam int OIDX_W = (MAX_OPTS > 1) ? $clog2(MAX_OPTS) : 1;
    localparam int WAIT_W = (FB_LAT > 1) ? $clog2(FB_LAT) : 1;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OPTS);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(FB_LAT - 1);
    localparam lidx_t             LAST_LINE = lidx_t'(LINES - 1);

    feeder_state_t               state_q, state_d;
    lidx_t                       cur_q, cur_d;
    logic [CNT_W-1:0]            idx_q, idx_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic [LINES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        stuck_q, stuck_d;
    logic                        err_q, err_d;
    logic [QCNT_W-1:0]           pass_len_q, pass_len_d;
    logic [QCNT_W-1:0]           pass_left_q, pass_left_d;
    logic [QCNT_W-1:0]           run_q, run_d;

    opt_t mem_q [LINES][MAX_OPTS];

    logic              line_ok, load_acc, load_rej;
    lidx_t             wr_line;
    logic              q_init, q_push, q_pop, q_empty;
    logic [LINES-1:0]  q_mask;
    lidx_t             q_head;
    logic [QCNT_W-1:0] q_count;

    // Out-of-range indices are redirected to line 0 only to keep the lookup in bounds;
    // such writes are rejected anyway.
    assign line_ok  = (load_line <= LAST_LINE);
    assign wr_line  = line_ok ? load_line : '0;
    assign load_acc = (state_q == LOAD) && load_valid && line_ok && (cnt_q[wr_line] != MAX_CNT);
    assign load_rej = (state_q == LOAD) && load_valid && !load_acc;

    always_ff @(posedge clk) begin
        if (load_acc) mem_q[wr_line][cnt_q[wr_line][OIDX_W-1:0]] <= load_opt;
    end

    line_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .init_i      (q_init),
        .init_mask_i (q_mask),
        .push_i      (q_push),
        .push_idx_i  (cur_q),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        stuck_d     = stuck_q;
        err_d       = err_q;
        pass_len_d  = pass_len_q;
        pass_left_d = pass_left_q;
        run_d       = run_q;
        q_init      = 1'b0;
        q_mask      = '0;
        q_push      = 1'b0;
        q_pop       = 1'b0;
        option      = '0;
        valid_op    = 1'b0;
        started     = 1'b0;
        done        = 1'b0;

        case (state_q)
            LOAD: begin
                if (load_acc) cnt_d[wr_line] = cnt_q[wr_line] + 1'b1;
                if (load_rej) err_d = 1'b1;
                if (load_done) begin
                    for (int i = 0; i < LINES; i++) q_mask[i] = (cnt_d[i] != '0);
                    q_init      = 1'b1;
                    pass_left_d = '0;
                    run_d       = '0;
                    state_d     = (|q_mask) ? HDR : DONE;
                end
            end
            HDR: begin
                started  = 1'b1;
                valid_op = 1'b1;
                option   = opt_t'(q_head);
                q_pop    = 1'b1;
                cur_d    = q_head;
                idx_d    = '0;
                // A pass spans exactly the lines queued when its first header is popped.
                if (pass_left_q == '0) begin
                    pass_len_d  = q_count;
                    pass_left_d = q_count - 1'b1;
                end else begin
                    pass_left_d = pass_left_q - 1'b1;
                end
                state_d = solved ? DONE : OPTS;
            end
            OPTS: begin
                started  = 1'b1;
                valid_op = 1'b1;
                option   = mem_q[cur_q][idx_q[OIDX_W-1:0]];
                if (idx_q == cnt_q[cur_q] - 1'b1) begin
                    state_d = WAIT;
                    wait_d  = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                if (solved) state_d = DONE;
            end
            WAIT: begin
                started = 1'b1;
                if (solved) begin
                    state_d = DONE;
                end else if (wait_q == LAST_WAIT) begin
                    if (put_back_to_FIFO) begin
                        run_d = run_q + 1'b1;
                        if (run_d >= pass_len_q) begin
                            stuck_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            q_push  = 1'b1;
                            state_d = HDR;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = q_empty ? DONE : HDR;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cur_q       <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            cnt_q       <= '0;
            stuck_q     <= 1'b0;
            err_q       <= 1'b0;
            pass_len_q  <= '0;
            pass_left_q <= '0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            stuck_q     <= stuck_d;
            err_q       <= err_d;
            pass_len_q  <= pass_len_d;
            pass_left_q <= pass_left_d;
            run_q       <= run_d;
        end
    end

    assign old_options_amnt = cnt_q;
    assign stuck            = stuck_q;
    assign load_err         = err_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_line_option_feeder.sv
// Bench for line_option_feeder: table-driven loads, scoreboarded option streams
// and hand-written sequences for put-back, stuck, solved, overflow and reset.
module tb_line_option_feeder;
    import nonogram_pkg::*;

    localparam int TB_MAX = 8;
    localparam int TB_LAT = 1;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        load_valid;
    lidx_t                       load_line;
    opt_t                        load_opt;
    logic                        load_done;
    logic                        started;
    opt_t                        option;
    logic                        valid_op;
    logic [LINES-1:0][CNT_W-1:0] old_options_amnt;
    logic                        put_back;
    logic                        solved;
    logic                        done;
    logic                        stuck;
    logic                        load_err;
    feeder_state_t               state_dbg;

    line_option_feeder #(.MAX_OPTS(TB_MAX), .FB_LAT(TB_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_valid       (load_valid),
        .load_line        (load_line),
        .load_opt         (load_opt),
        .load_done        (load_done),
        .started          (started),
        .option           (option),
        .valid_op         (valid_op),
        .old_options_amnt (old_options_amnt),
        .put_back_to_FIFO (put_back),
        .solved           (solved),
        .done             (done),
        .stuck            (stuck),
        .load_err         (load_err),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [2:0] line;
        logic [2:0] opt;
        logic       done;
        logic [6:0] exp_cnt;
        logic       exp_err;
    } load_vec_t;

    load_vec_t  board [12];
    load_vec_t  vec;
    int         exp_amnt [6];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_q [$];
    int         mq [$];
    logic [2:0] tb_mem [6][8];
    int         tb_cnt [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_line  = '0;
        load_opt   = '0;
        put_back   = 1'b0;
        solved     = 1'b0;
        step();
        step();
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) tb_cnt[i] = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_started"}, int'(started), 0);
        chk({tag, "_valid_op"}, int'(valid_op), 0);
        chk({tag, "_option"}, int'(option), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_load_err"}, int'(load_err), 0);
        chk({tag, "_state"}, int'(state_dbg), int'(LOAD));
        for (int i = 0; i < 6; i++) chk({tag, "_amnt"}, int'(old_options_amnt[i]), 0);
    endtask

    // Drives one load record for a cycle, then checks count/err after the edge.
    task automatic apply_load(input load_vec_t v);
        load_valid = v.vld;
        load_line  = v.line;
        load_opt   = v.opt;
        load_done  = v.done;
        step();
        load_valid = 1'b0;
        load_done  = 1'b0;
        if (v.vld && v.line < 6) chk("load_cnt", int'(old_options_amnt[v.line]), int'(v.exp_cnt));
        chk("load_err", int'(load_err), int'(v.exp_err));
        if (v.vld && v.line < 6 && tb_cnt[v.line] < TB_MAX) begin
            tb_mem[v.line][tb_cnt[v.line]] = v.opt;
            tb_cnt[v.line]++;
        end
        if (v.done) begin
            mq.delete();
            for (int i = 0; i < 6; i++) if (tb_cnt[i] > 0) mq.push_back(i);
        end
    endtask

    task automatic load_board();
        for (int i = 0; i < 12; i++) apply_load(board[i]);
    endtask

    // Streams the model's head line: header + options scoreboarded, then the feedback gap.
    task automatic stream_line(input bit pb);
        int ln;
        ln = mq.pop_front();
        exp_q.push_back(3'(ln));
        for (int k = 0; k < tb_cnt[ln]; k++) exp_q.push_back(tb_mem[ln][k]);
        chk("hdr_started", int'(started), 1);
        for (int k = 0; k <= tb_cnt[ln]; k++) begin
            chk("stream_valid", int'(valid_op), 1);
            if (valid_op) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_word: got %0d expected nothing", option);
                end else begin
                    chk("stream_word", int'(option), int'(exp_q.pop_front()));
                end
            end
            step();
        end
        for (int w = 0; w < TB_LAT; w++) begin
            chk("fb_gap", int'(valid_op), 0);
            if (w == TB_LAT - 1) put_back = pb;
            step();
            put_back = 1'b0;
        end
        if (pb) mq.push_back(ln);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        board = '{
            '{1'b1, 3'd5, 3'b100, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd0, 3'b110, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd4, 3'b110, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd1, 3'b100, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd5, 3'b010, 1'b0, 7'd2, 1'b0},
            '{1'b1, 3'd0, 3'b011, 1'b0, 7'd2, 1'b0},
            '{1'b1, 3'd2, 3'b101, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd1, 3'b010, 1'b0, 7'd2, 1'b0},
            '{1'b1, 3'd3, 3'b101, 1'b0, 7'd1, 1'b0},
            '{1'b1, 3'd4, 3'b011, 1'b0, 7'd2, 1'b0},
            '{1'b1, 3'd1, 3'b001, 1'b0, 7'd3, 1'b0},
            '{1'b1, 3'd5, 3'b001, 1'b1, 7'd3, 1'b0}
        };
        exp_amnt = '{2, 3, 1, 1, 2, 3};

        // Reset state, board load and the first two passes with lines 0/1 put back.
        do_reset();
        check_idle("reset");
        load_board();
        for (int i = 0; i < 6; i++) chk("amnt_after_load", int'(old_options_amnt[i]), exp_amnt[i]);
        stream_line(1'b1);
        stream_line(1'b1);
        for (int i = 0; i < 4; i++) stream_line(1'b0);
        stream_line(1'b0);
        stream_line(1'b0);
        chk("drain_done", int'(done), 1);
        chk("drain_started", int'(started), 0);
        chk("drain_stuck", int'(stuck), 0);
        chk("drain_state", int'(state_dbg), int'(DONE));
        load_valid = 1'b1;
        load_line  = 3'd2;
        load_opt   = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_valid_op", int'(valid_op), 0);
            chk("done_ignores_load", int'(old_options_amnt[2]), 1);
        end
        load_valid = 1'b0;

        // Every line of the first pass put back.
        do_reset();
        load_board();
        for (int i = 0; i < 5; i++) stream_line(1'b1);
        chk("pre_stuck", int'(stuck), 0);
        stream_line(1'b1);
        chk("stuck", int'(stuck), 1);
        chk("stuck_done", int'(done), 1);
        for (int i = 0; i < 4; i++) begin
            chk("stuck_valid_op", int'(valid_op), 0);
            step();
        end

        // Solved during line 1's options.
        do_reset();
        load_board();
        stream_line(1'b0);
        chk("sv_hdr", int'(option), 1);
        step();
        chk("sv_opt0", int'(option), 4);
        step();
        chk("sv_opt1_valid", int'(valid_op), 1);
        chk("sv_opt1", int'(option), 2);
        solved = 1'b1;
        step();
        solved = 1'b0;
        chk("sv_valid_op", int'(valid_op), 0);
        chk("sv_done", int'(done), 1);
        chk("sv_started", int'(started), 0);

        // Nine options into line 0, one into line 2; empty lines are skipped.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            vec = '{1'b1, 3'd0, 3'($urandom_range(0, 7)), 1'b0, 7'((i < 8) ? i + 1 : 8), (i == 8)};
            apply_load(vec);
        end
        vec = '{1'b1, 3'd2, 3'($urandom_range(0, 7)), 1'b0, 7'd1, 1'b1};
        apply_load(vec);
        vec = '{1'b0, 3'd0, 3'd0, 1'b1, 7'd0, 1'b1};
        apply_load(vec);
        chk("ovf_cnt0", int'(old_options_amnt[0]), 8);
        chk("ovf_cnt1", int'(old_options_amnt[1]), 0);
        stream_line(1'b0);
        stream_line(1'b0);
        chk("ovf_done", int'(done), 1);

        // Reset mid-OPTS, a bad index, then a clean reload.
        do_reset();
        load_board();
        step();
        chk("rst_in_opts", int'(valid_op), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_opts");
        vec = '{1'b1, 3'd7, 3'b101, 1'b0, 7'd0, 1'b1};
        apply_load(vec);
        do_reset();
        load_board();
        stream_line(1'b0);
        chk("reload_state", int'(state_dbg), int'(HDR));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
